hazard_sequencer: RTL and testbench
===================================

# hazard_sequencer

- Central pipeline-hazard controller for the 5-stage MIPS core.
- Decides each cycle whether the front end advances, stalls, or squashes, and whether the back end freezes.
- Drives the PC and IF/ID write enables, the IF squash, and the ID-stage bubble that feeds the control-zeroing block.
- Sequences multi-cycle redirect penalties and data-memory waits, with a timeout and saturating hazard counters.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter
- REDIRECT_PENALTY, 1, IF bubbles per taken control transfer (legal 1..3)
- MAX_MEM_WAIT, 15, consecutive busy cycles in MEM_WAIT before timeout (legal 1..255)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- jump, bne, jr  in  1 each  taken control transfer decoded in ID
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_Rt  in  5  load destination register
- IF_ID_Rs, IF_ID_Rt  in  5 each  source registers of the instruction in ID
- IF_ID_UsesRt  in  1  instruction in ID reads rt as a source
- mem_busy  in  1  data memory not ready this cycle
- count_clear  in  1  synchronous clear of both counters
- PC_write  out  1  PC load enable
- IF_ID_write  out  1  IF/ID register load enable
- IF_flush  out  1  squash the instruction being fetched
- ID_flush  out  1  insert a bubble into ID/EX (zeroes ID controls)
- EX_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB
- state  out  2  current FSM state
- err_timeout  out  1  sticky memory-wait timeout flag
- flush_count, stall_count  out  CNT_W each  hazard counters

## Operation
States:
- RUN=0
- REDIRECT=1
- MEM_WAIT=2
- TIMEOUT=3

Load-use hazard (lu) is true when all of the following hold:
- ID_EX_MemRead is 1.
- ID_EX_Rt is not 0.
- ID_EX_Rt equals IF_ID_Rs, or IF_ID_UsesRt is 1 and ID_EX_Rt equals IF_ID_Rt.

Default outputs: PC_write=1, IF_ID_write=1, IF_flush=0, ID_flush=0, EX_hold=0.

RUN. Conditions are evaluated in priority order:
1. mem_busy=1:
   - Outputs: PC_write=0, IF_ID_write=0, EX_hold=1.
   - Next state MEM_WAIT with wait_cnt=1.
2. lu=1:
   - Outputs: PC_write=0, IF_ID_write=0, ID_flush=1.
   - Stay in RUN. Any control transfer in ID is held and re-evaluated on the next cycle.
3. jump|bne|jr:
   - Outputs: IF_flush=1, ID_flush=bne|jr.
   - If REDIRECT_PENALTY>1, go to REDIRECT with pen_cnt=REDIRECT_PENALTY-1; otherwise stay in RUN.

REDIRECT:
- Outputs: IF_flush=1. jump, bne, jr and lu are ignored.
- pen_cnt decrements each cycle; return to RUN after the cycle in which pen_cnt=1.
- If mem_busy=1: go to MEM_WAIT and apply the MEM_WAIT outputs this cycle. pen_cnt is retained, not decremented.

MEM_WAIT:
- Outputs: PC_write=0, IF_ID_write=0, EX_hold=1, no flushes. All hazard inputs are ignored.
- If mem_busy=1: wait_cnt increments. When wait_cnt=MAX_MEM_WAIT, go to TIMEOUT.
- If mem_busy=0: go to REDIRECT if pen_cnt≠0, else RUN.

TIMEOUT:
- Outputs are the same as MEM_WAIT, plus err_timeout=1.
- Exit only through reset.

Counters:
- flush_count increments on every cycle with IF_flush=1.
- stall_count increments on every cycle with PC_write=0 while reset_n=1.
- Both saturate at all-ones.
- count_clear zeroes both and wins over a same-cycle increment.

## Timing
- All outputs except state, counters and err_timeout are combinational from (state, inputs), with zero-cycle response.
- state, pen_cnt, wait_cnt, counters and err_timeout are registered on the rising clk edge.
- While reset_n=0, independent of the clock:
  - state=RUN, pen_cnt=0, wait_cnt=0, counters=0, err_timeout=0.
  - PC_write=0, IF_ID_write=0, IF_flush=0, ID_flush=0, EX_hold=0.
- Deassertion of reset_n takes effect at the next rising edge. An assertion mid-redirect or mid-wait discards all pending state.
- MEM_WAIT exit costs one frozen cycle after mem_busy falls.
- Branch penalty is exactly REDIRECT_PENALTY cycles with IF_flush=1, excluding any MEM_WAIT cycles inserted in between.
- lu stalls last exactly 1 cycle, because the inserted bubble clears ID_EX_MemRead.

## Structure
- hazard_defs.vh (shared include):
  - State encodings `HS_RUN`, `HS_REDIRECT`, `HS_MEM_WAIT`, `HS_TIMEOUT`.
  - Register-zero constant.
- Sub-module sat_counter:
  - Parameter W; ports clk, reset_n, clear, inc, count.
  - Instantiated twice, for flush_count and stall_count.
- One FSM block (next-state logic plus registers), one combinational output decoder, one lu comparator.

## Test plan
- **Load-use:** ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 for one cycle → PC_write=0, IF_ID_write=0, ID_flush=1; stall_count=1; next cycle all defaults. Repeat with Rt=0 → no stall.
- **Redirect with penalty:** REDIRECT_PENALTY=3, bne pulse → IF_flush=1 for 3 consecutive cycles; ID_flush=1 only in the first cycle; flush_count=3; state RUN→1→1→0.
- **Jump and load-use together:** jump=1 and lu=1 in the same cycle → ID_flush=1, IF_flush=0. Next cycle jump still held, lu=0 → IF_flush=1, ID_flush=0.
- **Memory wait interrupting a redirect:** REDIRECT_PENALTY=3, jr, then mem_busy=1 for 4 cycles during the second penalty cycle → 5 frozen cycles, then 1 remaining REDIRECT cycle; flush_count=3.
- **Timeout and reset:** MAX_MEM_WAIT=4, mem_busy held at 1 → state=3 and err_timeout=1 after 4 busy cycles in MEM_WAIT, held until reset_n pulses low; all outputs take reset values asynchronously.
- **Counter saturation and clear:** CNT_W=4, 20 stall cycles → stall_count=15; count_clear together with an increment → 0.

Source files
------------

// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encodings,
// the register-zero constant and the load-use comparator.
package hazard_sequencer_pkg;

    typedef enum logic [1:0] {
        HS_RUN      = 2'd0,
        HS_REDIRECT = 2'd1,
        HS_MEM_WAIT = 2'd2,
        HS_TIMEOUT  = 2'd3
    } hs_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A load into $zero never creates a dependency, so it is excluded.
    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + ONE;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Central hazard controller: front-end stall/squash decisions, redirect
// penalty sequencing, data-memory waits with timeout, and hazard counters.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int CNT_W            = 16,
    parameter int REDIRECT_PENALTY = 1,
    parameter int MAX_MEM_WAIT     = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             jump,
    input  logic             bne,
    input  logic             jr,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rt,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             IF_ID_UsesRt,
    input  logic             mem_busy,
    input  logic             count_clear,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_flush,
    output logic             ID_flush,
    output logic             EX_hold,
    output logic [1:0]       state,
    output logic             err_timeout,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic       HAS_REDIRECT = (REDIRECT_PENALTY > 1);
    localparam logic [1:0] PEN_INIT     = 2'(REDIRECT_PENALTY - 1);
    localparam logic [7:0] WAIT_MAX     = 8'(MAX_MEM_WAIT);

    hs_state_e  state_q;
    logic [1:0] pen_q;
    logic [7:0] wait_q;
    logic       err_q;
    logic       lu;
    logic       ctl_xfer;

    assign lu       = load_use_hazard(ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt);
    assign ctl_xfer = jump | bne | jr;

    // pen_q survives a MEM_WAIT detour so the remaining penalty resumes afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HS_RUN;
            pen_q   <= 2'd0;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                HS_RUN: begin
                    if (mem_busy) begin
                        state_q <= HS_MEM_WAIT;
                        wait_q  <= 8'd1;
                    end else if (!lu && ctl_xfer && HAS_REDIRECT) begin
                        state_q <= HS_REDIRECT;
                        pen_q   <= PEN_INIT;
                    end
                end
                HS_REDIRECT: begin
                    if (mem_busy) begin
                        state_q <= HS_MEM_WAIT;
                        wait_q  <= 8'd1;
                    end else begin
                        pen_q <= pen_q - 2'd1;
                        if (pen_q == 2'd1) state_q <= HS_RUN;
                    end
                end
                HS_MEM_WAIT: begin
                    if (!mem_busy) begin
                        state_q <= (pen_q != 2'd0) ? HS_REDIRECT : HS_RUN;
                    end else if (wait_q == WAIT_MAX) begin
                        state_q <= HS_TIMEOUT;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_flush    = 1'b0;
        ID_flush    = 1'b0;
        EX_hold     = 1'b0;
        if (!reset_n) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
        end else if ((state_q == HS_MEM_WAIT) || (state_q == HS_TIMEOUT) || mem_busy) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            EX_hold     = 1'b1;
        end else if (state_q == HS_REDIRECT) begin
            IF_flush = 1'b1;
        end else if (lu) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_flush    = 1'b1;
        end else if (ctl_xfer) begin
            IF_flush = 1'b1;
            ID_flush = bne | jr;
        end
    end

    assign state       = state_q;
    assign err_timeout = err_q;

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (count_clear),
        .inc     (IF_flush),
        .count   (flush_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (count_clear),
        .inc     (~PC_write & reset_n),
        .count   (stall_count)
    );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model.
module tb_hazard_sequencer;

  localparam int CNT_W = 4;
  localparam int PEN   = 3;
  localparam int MAXW  = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic jump = 0, bne = 0, jr = 0, ID_EX_MemRead = 0, IF_ID_UsesRt = 0;
  logic mem_busy = 0, count_clear = 0;
  logic [4:0] ID_EX_Rt = 0, IF_ID_Rs = 0, IF_ID_Rt = 0;
  logic PC_write, IF_ID_write, IF_flush, ID_flush, EX_hold, err_timeout;
  logic [1:0] state;
  logic [CNT_W-1:0] flush_count, stall_count;

  int checks = 0;
  int failures = 0;

  // behavioural model: current and next values, expected combinational outputs
  logic [1:0] m_state = 0, n_state;
  int m_pen = 0, n_pen, m_wait = 0, n_wait, m_flush = 0, n_flush, m_stall = 0, n_stall;
  logic m_err = 0, n_err;
  logic e_pc, e_ifid, e_iff, e_idf, e_hold;

  hazard_sequencer #(.CNT_W(CNT_W), .REDIRECT_PENALTY(PEN), .MAX_MEM_WAIT(MAXW)) dut (
    .clk(clk), .reset_n(reset_n), .jump(jump), .bne(bne), .jr(jr),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt), .IF_ID_Rs(IF_ID_Rs),
    .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt), .mem_busy(mem_busy),
    .count_clear(count_clear), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .IF_flush(IF_flush), .ID_flush(ID_flush), .EX_hold(EX_hold), .state(state),
    .err_timeout(err_timeout), .flush_count(flush_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic model_eval();
    logic lu_m, ctl;
    lu_m = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
           ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
    ctl = jump | bne | jr;
    {e_pc, e_ifid, e_iff, e_idf, e_hold} = 5'b11000;
    n_state = m_state; n_pen = m_pen; n_wait = m_wait; n_err = m_err;
    if (!reset_n) begin
      {e_pc, e_ifid, e_iff, e_idf, e_hold} = 5'b00000;
      n_state = 0; n_pen = 0; n_wait = 0; n_err = 0;
    end else if (m_state >= 2'd2 || mem_busy) begin
      e_pc = 0; e_ifid = 0; e_hold = 1;
      if (m_state <= 2'd1) begin
        n_state = 2; n_wait = 1;
      end else if (m_state == 2'd2) begin
        if (!mem_busy) n_state = (m_pen != 0) ? 2'd1 : 2'd0;
        else if (m_wait == MAXW) begin n_state = 3; n_err = 1; end
        else n_wait = m_wait + 1;
      end
    end else if (m_state == 2'd1) begin
      e_iff = 1; n_pen = m_pen - 1;
      if (n_pen == 0) n_state = 0;
    end else if (lu_m) begin
      e_pc = 0; e_ifid = 0; e_idf = 1;
    end else if (ctl) begin
      e_iff = 1; e_idf = bne | jr;
      if (PEN > 1) begin n_state = 1; n_pen = PEN - 1; end
    end
    if (!reset_n || count_clear) begin
      n_flush = 0; n_stall = 0;
    end else begin
      n_flush = (e_iff && m_flush < CMAX) ? m_flush + 1 : m_flush;
      n_stall = (!e_pc && m_stall < CMAX) ? m_stall + 1 : m_stall;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pen = 0; m_wait = 0; m_err = 0; m_flush = 0; m_stall = 0;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    m_state = n_state; m_pen = n_pen; m_wait = n_wait; m_err = n_err;
    m_flush = n_flush; m_stall = n_stall;
    #1;
  endtask

  task automatic idle_inputs();
    jump = 0; bne = 0; jr = 0; ID_EX_MemRead = 0; IF_ID_UsesRt = 0;
    mem_busy = 0; count_clear = 0; ID_EX_Rt = 0; IF_ID_Rs = 0; IF_ID_Rt = 0;
  endtask

  task automatic clear_counts();
    count_clear = 1; tick(); count_clear = 0;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if ({PC_write, IF_ID_write, IF_flush, ID_flush, EX_hold} !== 5'b00000) begin
      $display("FAIL reset_outputs: got %b expected 00000", {PC_write, IF_ID_write, IF_flush, ID_flush, EX_hold});
      failures++;
    end
    checks++;
    if (state !== 2'd0 || err_timeout !== 1'b0 || flush_count !== 0 || stall_count !== 0) begin
      $display("FAIL reset_regs: state=%0d err=%0d flush=%0d stall=%0d expected all 0", state, err_timeout, flush_count, stall_count);
      failures++;
    end
    tick(); tick();
    reset_n = 1;
    #1;
    checks++;
    if ({PC_write, IF_ID_write, IF_flush, ID_flush, EX_hold} !== 5'b11000) begin
      $display("FAIL post_reset_defaults: got %b expected 11000", {PC_write, IF_ID_write, IF_flush, ID_flush, EX_hold});
      failures++;
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_counts();
    ID_EX_MemRead = 1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8;
    #1;
    checks++;
    if ({PC_write, IF_ID_write, ID_flush, IF_flush, EX_hold} !== 5'b00100) begin
      $display("FAIL lu_stall: got %b expected 00100", {PC_write, IF_ID_write, ID_flush, IF_flush, EX_hold});
      failures++;
    end
    tick();
    ID_EX_MemRead = 0;
    #1;
    checks++;
    if (stall_count !== 1 || PC_write !== 1'b1 || ID_flush !== 1'b0) begin
      $display("FAIL lu_after: stall=%0d pc=%0d idf=%0d expected 1 1 0", stall_count, PC_write, ID_flush);
      failures++;
    end
    ID_EX_MemRead = 1; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0;
    #1;
    checks++;
    if (PC_write !== 1'b1 || ID_flush !== 1'b0) begin
      $display("FAIL lu_reg_zero: pc=%0d idf=%0d expected 1 0", PC_write, ID_flush);
      failures++;
    end
    ID_EX_Rt = 5'd9; IF_ID_Rs = 5'd1; IF_ID_Rt = 5'd9; IF_ID_UsesRt = 1;
    #1;
    checks++;
    if (PC_write !== 1'b0) begin
      $display("FAIL lu_rt_used: pc=%0d expected 0", PC_write);
      failures++;
    end
    IF_ID_UsesRt = 0;
    #1;
    checks++;
    if (PC_write !== 1'b1) begin
      $display("FAIL lu_rt_unused: pc=%0d expected 1", PC_write);
      failures++;
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_redirect();
    logic [1:0] exp_st [3] = '{2'd0, 2'd1, 2'd1};
    clear_counts();
    bne = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (IF_flush !== 1'b1 || ID_flush !== (i == 0) || state !== exp_st[i]) begin
        $display("FAIL redirect_cyc%0d: iff=%0d idf=%0d state=%0d expected 1 %0d %0d", i, IF_flush, ID_flush, state, (i == 0), exp_st[i]);
        failures++;
      end
      tick();
      bne = 0;
    end
    #1;
    checks++;
    if (state !== 2'd0 || IF_flush !== 1'b0 || flush_count !== 3) begin
      $display("FAIL redirect_end: state=%0d iff=%0d flush=%0d expected 0 0 3", state, IF_flush, flush_count);
      failures++;
    end
  endtask

  task automatic test_jump_lu();
    jump = 1; ID_EX_MemRead = 1; ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd5;
    #1;
    checks++;
    if (ID_flush !== 1'b1 || IF_flush !== 1'b0 || PC_write !== 1'b0) begin
      $display("FAIL jump_lu_first: idf=%0d iff=%0d pc=%0d expected 1 0 0", ID_flush, IF_flush, PC_write);
      failures++;
    end
    tick();
    ID_EX_MemRead = 0;
    #1;
    checks++;
    if (IF_flush !== 1'b1 || ID_flush !== 1'b0) begin
      $display("FAIL jump_lu_second: iff=%0d idf=%0d expected 1 0", IF_flush, ID_flush);
      failures++;
    end
    tick();
    idle_inputs();
    tick(); tick();
    checks++;
    if (state !== 2'd0) begin
      $display("FAIL jump_lu_end: state=%0d expected 0", state);
      failures++;
    end
  endtask

  task automatic test_mem_in_redirect();
    int frozen = 0;
    int guard = 0;
    clear_counts();
    jr = 1; tick(); jr = 0; tick();
    for (int i = 0; i < 4; i++) begin
      mem_busy = 1;
      #1;
      if (EX_hold === 1'b1 && PC_write === 1'b0 && IF_flush === 1'b0) frozen++;
      tick();
    end
    mem_busy = 0;
    #1;
    while (EX_hold === 1'b1 && guard < 10) begin
      frozen++; guard++; tick();
    end
    checks++;
    if (frozen !== 5) begin
      $display("FAIL mem_redirect_frozen: got %0d cycles expected 5", frozen);
      failures++;
    end
    checks++;
    if (state !== 2'd1 || IF_flush !== 1'b1) begin
      $display("FAIL mem_redirect_resume: state=%0d iff=%0d expected 1 1", state, IF_flush);
      failures++;
    end
    tick();
    checks++;
    if (state !== 2'd0 || flush_count !== 3) begin
      $display("FAIL mem_redirect_end: state=%0d flush=%0d expected 0 3", state, flush_count);
      failures++;
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    mem_busy = 1;
    while (state !== 2'd3 && n < 20) begin
      tick(); n++;
    end
    checks++;
    if (n !== 5 || err_timeout !== 1'b1) begin
      $display("FAIL timeout_entry: cycles=%0d err=%0d expected 5 1", n, err_timeout);
      failures++;
    end
    mem_busy = 0;
    tick(); tick(); tick();
    checks++;
    if (state !== 2'd3 || err_timeout !== 1'b1 || PC_write !== 1'b0 || EX_hold !== 1'b1) begin
      $display("FAIL timeout_sticky: state=%0d err=%0d pc=%0d hold=%0d expected 3 1 0 1", state, err_timeout, PC_write, EX_hold);
      failures++;
    end
    reset_n = 0;
    model_reset();
    #1;
    checks++;
    if (state !== 2'd0 || err_timeout !== 1'b0 || EX_hold !== 1'b0 || PC_write !== 1'b0 || stall_count !== 0) begin
      $display("FAIL async_reset: state=%0d err=%0d hold=%0d pc=%0d stall=%0d expected 0 0 0 0 0", state, err_timeout, EX_hold, PC_write, stall_count);
      failures++;
    end
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_saturation();
    clear_counts();
    ID_EX_MemRead = 1; ID_EX_Rt = 5'd3; IF_ID_Rs = 5'd3;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (stall_count !== 4'd15) begin
      $display("FAIL stall_saturate: got %0d expected 15", stall_count);
      failures++;
    end
    count_clear = 1;
    tick();
    count_clear = 0;
    checks++;
    if (stall_count !== 4'd0) begin
      $display("FAIL clear_wins: got %0d expected 0", stall_count);
      failures++;
    end
    tick();
    checks++;
    if (stall_count !== 4'd1) begin
      $display("FAIL count_after_clear: got %0d expected 1", stall_count);
      failures++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      jump = ($urandom_range(0, 7) == 0);
      bne = ($urandom_range(0, 7) == 0);
      jr = ($urandom_range(0, 9) == 0);
      ID_EX_MemRead = $urandom_range(0, 1);
      ID_EX_Rt = 5'($urandom_range(0, 3));
      IF_ID_Rs = 5'($urandom_range(0, 3));
      IF_ID_Rt = 5'($urandom_range(0, 3));
      IF_ID_UsesRt = $urandom_range(0, 1);
      mem_busy = ($urandom_range(0, 4) == 0);
      count_clear = ($urandom_range(0, 39) == 0);
      if (reset_n == 1'b0) reset_n = 1;
      else if ($urandom_range(0, 49) == 0) begin
        reset_n = 0;
        model_reset();
      end
      #1;
      model_eval();
      checks++;
      if ({PC_write, IF_ID_write, IF_flush, ID_flush, EX_hold} !== {e_pc, e_ifid, e_iff, e_idf, e_hold}) begin
        $display("FAIL rand_outputs cyc%0d: got %b expected %b", i, {PC_write, IF_ID_write, IF_flush, ID_flush, EX_hold}, {e_pc, e_ifid, e_iff, e_idf, e_hold});
        failures++;
      end
      checks++;
      if (state !== m_state || err_timeout !== m_err) begin
        $display("FAIL rand_state cyc%0d: state=%0d err=%0d expected %0d %0d", i, state, err_timeout, m_state, m_err);
        failures++;
      end
      checks++;
      if (flush_count !== CNT_W'(m_flush) || stall_count !== CNT_W'(m_stall)) begin
        $display("FAIL rand_counts cyc%0d: flush=%0d stall=%0d expected %0d %0d", i, flush_count, stall_count, m_flush, m_stall);
        failures++;
      end
      tick();
    end
    idle_inputs();
    reset_n = 1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_jump_lu();
    test_mem_in_redirect();
    test_timeout();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
